csr_counters: RTL
=================

CSR_COUNTERS -- requirements
Module: csr_counters

Interface
REQ-001 SHALL have parameter NUM_HPM, default 4, meaning number of programmable counters mhpmcounter3..(3+NUM_HPM-1), legal range 0..29.
REQ-002 SHALL have parameter CNT_WIDTH, default 64, meaning implemented bits per counter, legal range 33..64.
REQ-003 SHALL have parameter NUM_EVENTS, default 8, meaning width of the events input, legal range 1..255.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port inc_instret  input  1  one instruction retired this cycle.
REQ-007 SHALL have port events  input  NUM_EVENTS  per-cycle event pulses, bit k = event k+1.
REQ-008 SHALL have port addr  input  12  CSR address.
REQ-009 SHALL have port write  input  2  op: 00 none, 01 write, 10 set (old | data_in), 11 clear (old & ~data_in).
REQ-010 SHALL have port data_in  input  32  write operand.
REQ-011 SHALL have port data_out  output  32  combinational read of addr, pre-write value.
REQ-012 SHALL have port illegal  output  1  combinational; addr unimplemented, or write != 00 to a read-only address.
REQ-013 SHALL have port ovf_irq  output  1  counter-overflow interrupt request.

Function
REQ-014 SHALL map: cycle 0xB00/0xB80 (lo/hi), instret 0xB02/0xB82, mhpmcounterN 0xB00+N / 0xB80+N, N = 3..NUM_HPM+2; read-only shadows at 0xC00-range (same offsets); mcountinhibit 0x320; mhpmeventN 0x320+N.
REQ-015 SHALL read-only-shadow behaviour: 0xCxx reads equal the 0xBxx value; writes to 0xCxx assert illegal and change no state.
REQ-016 SHALL apply a write only when write != 00 and illegal == 0; the new value is computed from the current data_out.
REQ-017 SHALL, for a lo write, replace bits [31:0]; for a hi write, replace bits [CNT_WIDTH-1:32]; the other half is unchanged; hi-read bits at and above CNT_WIDTH-32 return 0.
REQ-018 SHALL increment cycle every cycle unless inhibited; instret when inc_instret=1 unless inhibited; mhpmcounterN when its selected event bit is 1 unless inhibited.
REQ-019 SHALL give a CSR write to a counter priority over that counter's increment in the same cycle, so the increment is lost; other counters are unaffected.
REQ-020 SHALL wrap a counter from 2^CNT_WIDTH-1 to 0 on increment.
REQ-021 SHALL implement mcountinhibit bit 0 (CY), bit 2 (IR), and bits 3..NUM_HPM+2 (HPM); other bits read 0 and ignore writes; a set bit freezes the counter from the next cycle.
REQ-022 SHALL store mhpmeventN[7:0] as the event selector: 0 or >NUM_EVENTS counts nothing; k selects events[k-1]; bits [30:8] read 0.
REQ-023 SHALL keep read latency at 0 cycles and write/increment latency at 1 cycle (visible on the next cycle's data_out).

Reset
REQ-024 SHALL, when reset_n=0 at a clock edge, zero all counters, mcountinhibit, all mhpmevent registers, and OF bits; reset overrides any simultaneous write or increment.
REQ-025 SHALL hold ovf_irq=0 in the cycle after reset; data_out follows reset state combinationally.

Configuration
REQ-026 SHALL, with CSR_HPM_OVF_IRQ_EN defined, set mhpmeventN[31] (OF) when mhpmcounterN wraps by increment, with OF writable via mhpmevent; ovf_irq is a register equal to OR of all OF bits, updated 1 cycle after the wrap.
REQ-027 SHALL, without CSR_HPM_OVF_IRQ_EN, read mhpmeventN[31] as 0, ignore writes to it, and tie ovf_irq to 0.
REQ-028 SHALL, with the macro defined, let a same-cycle mhpmevent write of OF take priority over a wrap setting it.

Verification
REQ-029 SHALL cover: reset, then 10 idle cycles -> read 0xC00 = 10 (+/-0 per defined sample point), 0xC80 = 0.
REQ-030 SHALL cover: write 0xB80=0, 0xB00=0xFFFFFFFF -> 1 cycle later 0xB00=0, 0xB80=1.
REQ-031 SHALL cover: write 0x320 = 0x5 -> cycle and instret frozen while inc_instret=1; clear 0x320 -> counting resumes.
REQ-032 SHALL cover: mhpmevent3=2, pulse events[1] 7 times, events[0] 5 times -> 0xB03 = 7; mhpmevent3=200 -> no further counting.
REQ-033 SHALL cover: write 0xC02 with write=01 -> illegal=1, instret unchanged; read 0xB03+NUM_HPM -> illegal=1, data_out=0.
REQ-034 SHALL cover (macro defined, CNT_WIDTH=40): mhpmcounter3 = 2^40-1, one event -> counter 0, mhpmevent3[31]=1, ovf_irq=1 next cycle; clear bit 31 -> ovf_irq=0.

Source files
------------

// File: rtl/csr_counters.sv
// Machine counter CSR block: cycle, instret, NUM_HPM event counters, mcountinhibit, mhpmevent selectors.
// Optional overflow interrupt (OF bits in mhpmevent[31], ovf_irq) enabled by defining CSR_HPM_OVF_IRQ_EN.
module csr_counters #(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inc_instret,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic [11:0]           addr,
    input  logic [1:0]            write,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  illegal,
    output logic                  ovf_irq
);

    // Counter arrays are indexed by the low address bits; index 1 (time) is unused and stays zero.
    localparam int NCNT = NUM_HPM + 3;
    localparam int HI_W = CNT_WIDTH - 32;
    localparam logic [31:0] INHIBIT_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    csr_op_e              op;
    logic [CNT_WIDTH-1:0] cnt_q   [NCNT];
    logic [7:0]           evsel_q [NCNT];
    logic [31:0]          inhibit_q;
    logic [NCNT-1:0]      of_q;
    logic [NCNT-1:0]      cnt_inc;
    logic [NCNT-1:0]      cnt_wr;
    logic [NCNT-1:0]      evt_wr;
    logic [4:0]           idx;
    logic                 hi_sel, ro_sel, cnt_sel, inh_sel, evt_sel;
    logic [31:0]          wdata;
    logic                 we;

    function automatic logic impl_hpm(input logic [4:0] n);
        return (n >= 5'd3) && (int'(n) < NCNT);
    endfunction

    function automatic logic event_hit(input logic [7:0] sel, input logic [NUM_EVENTS-1:0] ev);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_EVENTS; k++)
            if (sel == 8'(k + 1)) hit = ev[k];
        return hit;
    endfunction

    assign op = csr_op_e'(write);

    always_comb begin
        idx     = addr[4:0];
        hi_sel  = addr[7];
        ro_sel  = (addr[11:8] == 4'hC);
        cnt_sel = (addr[11:8] == 4'hB || ro_sel) && (addr[6:5] == 2'b00)
                  && (idx == 5'd0 || idx == 5'd2 || impl_hpm(idx));
        inh_sel = (addr == 12'h320);
        evt_sel = (addr[11:5] == 7'h19) && impl_hpm(idx);
        illegal = !(cnt_sel || inh_sel || evt_sel) || (op != OP_NONE && ro_sel);
        we      = (op != OP_NONE) && !illegal;
    end

    always_comb begin
        logic [63:0] cnt_ext;
        // NOTE: every output gets a default first, so no path through the block can infer a latch.
        cnt_ext  = '0;
        data_out = '0;
        for (int n = 0; n < NCNT; n++)
            if (idx == 5'(n)) cnt_ext = 64'(cnt_q[n]);
        if (cnt_sel) begin
            data_out = hi_sel ? cnt_ext[63:32] : cnt_ext[31:0];
        end else if (inh_sel) begin
            data_out = inhibit_q;
        end else if (evt_sel) begin
            for (int n = 0; n < NCNT; n++)
                if (idx == 5'(n)) data_out = {of_q[n], 23'd0, evsel_q[n]};
        end
    end

    // Read-modify-write operand is always derived from the pre-write read value.
    always_comb begin
        case (op)
            OP_WRITE: wdata = data_in;
            OP_SET:   wdata = data_out | data_in;
            OP_CLEAR: wdata = data_out & ~data_in;
            default:  wdata = data_out;
        endcase
    end

    always_comb begin
        cnt_inc = '0;
        cnt_wr  = '0;
        evt_wr  = '0;
        for (int n = 0; n < NCNT; n++) begin
            if (n == 0)      cnt_inc[n] = ~inhibit_q[n];
            else if (n == 2) cnt_inc[n] = inc_instret & ~inhibit_q[n];
            else if (n >= 3) cnt_inc[n] = event_hit(evsel_q[n], events) & ~inhibit_q[n];
            cnt_wr[n] = we && cnt_sel && (idx == 5'(n));
            evt_wr[n] = we && evt_sel && (idx == 5'(n));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inhibit_q <= '0;
            // NOTE: the counter and selector arrays are architectural registers, so each entry is cleared.
            for (int n = 0; n < NCNT; n++) begin
                cnt_q[n]   <= '0;
                evsel_q[n] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates keep every counter working from the same pre-edge values.
            if (we && inh_sel) inhibit_q <= wdata & INHIBIT_MASK;
            for (int n = 0; n < NCNT; n++) begin
                if (cnt_wr[n]) begin
                    if (hi_sel) cnt_q[n][CNT_WIDTH-1:32] <= wdata[HI_W-1:0];
                    else        cnt_q[n][31:0]           <= wdata;
                end else if (cnt_inc[n]) begin
                    cnt_q[n] <= cnt_q[n] + CNT_WIDTH'(1);
                end
                if (evt_wr[n]) evsel_q[n] <= wdata[7:0];
            end
        end
    end

`ifdef CSR_HPM_OVF_IRQ_EN
    logic [NCNT-1:0] of_d;

    // A software write of OF wins over a wrap in the same cycle.
    always_comb begin
        of_d = of_q;
        for (int n = 3; n < NCNT; n++) begin
            if (evt_wr[n])
                of_d[n] = wdata[31];
            else if (cnt_inc[n] && !cnt_wr[n] && (&cnt_q[n]))
                of_d[n] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            of_q    <= '0;
            ovf_irq <= 1'b0;
        end else begin
            of_q    <= of_d;
            ovf_irq <= |of_d;
        end
    end
`else
    assign of_q    = '0;
    assign ovf_irq = 1'b0;
`endif

endmodule
